// File: rtl/bcd_multi_counter.sv
// Purpose: N-digit BCD up/down counter with per-digit 0-9 / 0-5 modulus, wrap or saturate, clear and load.
// Latency: count and wrap_pulse update one clk after the sampled tick/clear/load; flags decode the registered count.
// Backpressure: none; pause masks tick_en, and clear/load always take effect.
module bcd_multi_counter #(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] SEXA_MASK  = 4'b0010,
  parameter bit                    WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic                    up_down,
  input  logic                    pause,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap_pulse,
  output logic                    at_max,
  output logic                    at_zero
);

  // Largest legal value of digit i: 5 for the tens-of-seconds style digits, 9 otherwise.
  function automatic logic [3:0] digit_max(input int i);
    return SEXA_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  logic [4*NUM_DIGITS-1:0] inc_val;
  logic [4*NUM_DIGITS-1:0] dec_val;
  logic [4*NUM_DIGITS-1:0] clamp_val;
  logic                    carry_out;
  logic                    borrow_out;
  logic                    all_max;
  logic                    all_zero;
  logic                    carry;
  logic                    borrow;
  logic [3:0]              dig;
  logic [3:0]              ldig;

  // Ripple carry/borrow chains, load clamping and limit decodes, all in one pass over the digits.
  always_comb begin
    inc_val   = count;
    dec_val   = count;
    clamp_val = '0;
    carry     = 1'b1;
    borrow    = 1'b1;
    all_max   = 1'b1;
    all_zero  = 1'b1;
    dig       = '0;
    ldig      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig  = count[4*i +: 4];
      ldig = load_value[4*i +: 4];
      if (carry) begin
        if (dig >= digit_max(i)) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*i +: 4] = digit_max(i);
        end else begin
          dec_val[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      clamp_val[4*i +: 4] = (ldig > digit_max(i)) ? digit_max(i) : ldig;
      if (dig != digit_max(i)) all_max = 1'b0;
      if (dig != 4'd0) all_zero = 1'b0;
    end
    // A chain that runs off the top digit means the whole counter crossed its limit.
    carry_out  = carry;
    borrow_out = borrow;
  end

  // Counter register: clear beats load beats an unpaused tick; wrap_pulse marks a rollover edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= clamp_val;
      end else if (tick_en && !pause) begin
        if (up_down) begin
          if (!carry_out) begin
            count <= inc_val;
          end else if (WRAP) begin
            count      <= inc_val;
            wrap_pulse <= 1'b1;
          end
        end else begin
          if (!borrow_out) begin
            count <= dec_val;
          end else if (WRAP) begin
            count      <= dec_val;
            wrap_pulse <= 1'b1;
          end
        end
      end
    end
  end

  assign at_max  = all_max;
  assign at_zero = all_zero;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Bench for bcd_multi_counter: three configurations (MM:SS wrap, MM:SS saturate, 2-digit decimal)
// share one stimulus stream; a mixed-radix integer model predicts every output on every cycle,
// and directed literal checks pin the model against hand-computed values.
module tb_bcd_multi_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_en = 1'b0;
  logic        up_down = 1'b1;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;

  logic [15:0] count_a, count_b;
  logic [7:0]  count_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic        max_a, max_b, max_c;
  logic        zero_a, zero_b, zero_c;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_multi_counter u_mmss (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up_down(up_down), .pause(pause),
    .clear(clear), .load(load), .load_value(load_value),
    .count(count_a), .wrap_pulse(wrap_a), .at_max(max_a), .at_zero(zero_a)
  );

  bcd_multi_counter #(.NUM_DIGITS(4), .SEXA_MASK(4'b0010), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up_down(up_down), .pause(pause),
    .clear(clear), .load(load), .load_value(load_value),
    .count(count_b), .wrap_pulse(wrap_b), .at_max(max_b), .at_zero(zero_b)
  );

  bcd_multi_counter #(.NUM_DIGITS(2), .SEXA_MASK(2'b00), .WRAP(1'b1)) u_dec (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up_down(up_down), .pause(pause),
    .clear(clear), .load(load), .load_value(load_value[7:0]),
    .count(count_c), .wrap_pulse(wrap_c), .at_max(max_c), .at_zero(zero_c)
  );

  // Model: each counter is an integer in [0, product of digit radices).
  localparam int NDIG[3] = '{4, 4, 2};
  localparam int MASK[3] = '{2, 2, 0};
  localparam int WRP[3]  = '{1, 0, 1};

  int mv[3];
  bit mw[3];

  function automatic int radix(input int k, input int i);
    return ((MASK[k] >> i) & 1) != 0 ? 6 : 10;
  endfunction

  function automatic int modulus(input int k);
    int m = 1;
    for (int i = 0; i < NDIG[k]; i++) m = m * radix(k, i);
    return m;
  endfunction

  function automatic logic [31:0] to_bcd(input int k, input int v);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG[k]; i++) begin
      r[4*i +: 4] = 4'(t % radix(k, i));
      t = t / radix(k, i);
    end
    return r;
  endfunction

  function automatic int from_load(input int k, input logic [15:0] lv);
    int v = 0;
    int w = 1;
    int d;
    for (int i = 0; i < NDIG[k]; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > radix(k, i) - 1) d = radix(k, i) - 1;
      v = v + d * w;
      w = w * radix(k, i);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edges the DUT sees.
  always @(posedge clk or posedge rst) begin
    int m;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mv[k] = 0;
        mw[k] = 1'b0;
      end else begin
        mw[k] = 1'b0;
        m = modulus(k);
        if (clear) mv[k] = 0;
        else if (load) mv[k] = from_load(k, load_value);
        else if (tick_en && !pause) begin
          if (up_down) begin
            if (mv[k] == m - 1) begin
              if (WRP[k] != 0) begin mv[k] = 0; mw[k] = 1'b1; end
            end else mv[k] = mv[k] + 1;
          end else begin
            if (mv[k] == 0) begin
              if (WRP[k] != 0) begin mv[k] = m - 1; mw[k] = 1'b1; end
            end else mv[k] = mv[k] - 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cnt_a",  {16'b0, count_a}, to_bcd(0, mv[0]));
      chk("wrap_a", {31'b0, wrap_a},  {31'b0, mw[0]});
      chk("max_a",  {31'b0, max_a},   {31'b0, mv[0] == modulus(0) - 1});
      chk("zero_a", {31'b0, zero_a},  {31'b0, mv[0] == 0});
      chk("cnt_b",  {16'b0, count_b}, to_bcd(1, mv[1]));
      chk("wrap_b", {31'b0, wrap_b},  {31'b0, mw[1]});
      chk("max_b",  {31'b0, max_b},   {31'b0, mv[1] == modulus(1) - 1});
      chk("zero_b", {31'b0, zero_b},  {31'b0, mv[1] == 0});
      chk("cnt_c",  {24'b0, count_c}, to_bcd(2, mv[2]));
      chk("wrap_c", {31'b0, wrap_c},  {31'b0, mw[2]});
      chk("max_c",  {31'b0, max_c},   {31'b0, mv[2] == modulus(2) - 1});
      chk("zero_c", {31'b0, zero_c},  {31'b0, mv[2] == 0});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_tick(input logic dir);
    tick_en = 1'b1; up_down = dir;
    step();
    tick_en = 1'b0;
  endtask

  initial begin
    int wraps;
    int iv;
    // Reset asserted off any clock edge must clear outputs at once.
    #12 rst = 1'b1;
    #1;
    chk("rst_cnt",  {16'b0, count_a}, 32'h0);
    chk("rst_zero", {31'b0, zero_a},  32'h1);
    chk("rst_max",  {31'b0, max_a},   32'h0);
    chk("rst_wrap", {31'b0, wrap_a},  32'h0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (10) step();
    chk("idle_cnt", {16'b0, count_a}, 32'h0);

    // MM:SS carries.
    do_load(16'h0959);
    do_tick(1'b1);
    chk("carry_0959", {16'b0, count_a}, 32'h1000);
    chk("carry_wrap", {31'b0, wrap_a},  32'h0);
    do_load(16'h0059);
    do_tick(1'b1);
    chk("carry_0059", {16'b0, count_a}, 32'h0100);

    // Full wrap up.
    do_load(16'h9959);
    chk("at_max_9959", {31'b0, max_a}, 32'h1);
    do_tick(1'b1);
    chk("wrapup_cnt",  {16'b0, count_a}, 32'h0);
    chk("wrapup_pls",  {31'b0, wrap_a},  32'h1);
    chk("wrapup_zero", {31'b0, zero_a},  32'h1);
    chk("sat_up_hold", {16'b0, count_b}, 32'h9959);
    chk("sat_up_pls",  {31'b0, wrap_b},  32'h0);
    step();
    chk("wrapup_pls_drop", {31'b0, wrap_a}, 32'h0);

    // Underflow.
    clear = 1'b1; step(); clear = 1'b0;
    do_tick(1'b0);
    chk("under_cnt",   {16'b0, count_a}, 32'h9959);
    chk("under_pls",   {31'b0, wrap_a},  32'h1);
    chk("sat_dn_cnt",  {16'b0, count_b}, 32'h0);
    chk("sat_dn_pls",  {31'b0, wrap_b},  32'h0);
    chk("dec_under",   {24'b0, count_c}, 32'h99);

    // Pause holds for five ticks.
    pause = 1'b1; tick_en = 1'b1; up_down = 1'b1;
    repeat (5) step();
    tick_en = 1'b0; pause = 1'b0;
    chk("pause_hold", {16'b0, count_a}, 32'h9959);

    // Clear wins over load and tick.
    clear = 1'b1; load = 1'b1; load_value = 16'h1234; tick_en = 1'b1;
    step();
    clear = 1'b0; load = 1'b0; tick_en = 1'b0;
    chk("prio_clear", {16'b0, count_a}, 32'h0);

    // Per-digit clamping on load.
    do_load(16'hFC7A);
    chk("clamp_a", {16'b0, count_a}, 32'h9959);
    chk("clamp_c", {24'b0, count_c}, 32'h79);

    // Decimal 2-digit: 100 consecutive ticks, one wrap.
    clear = 1'b1; step(); clear = 1'b0;
    tick_en = 1'b1; up_down = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      iv = i % 100;
      chk("dec_seq", {24'b0, count_c}, 32'((iv / 10) * 16 + (iv % 10)));
      if (wrap_c) wraps++;
    end
    tick_en = 1'b0;
    chk("dec_wraps", 32'(wraps), 32'd1);

    // Randomized operation with occasional mid-cycle resets.
    for (int i = 0; i < 4000; i++) begin
      clear      = ($urandom_range(0, 40) == 0);
      load       = ($urandom_range(0, 25) == 0);
      load_value = 16'($urandom);
      tick_en    = ($urandom_range(0, 3) != 0);
      pause      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) up_down = ~up_down;
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", {16'b0, count_a}, 32'h0);
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    clear = 1'b0; load = 1'b0; tick_en = 1'b0; pause = 1'b0;
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_multi_counter.md
Name: bcd_multi_counter

Overview:
- Parametrised N-digit BCD up/down counter that feeds the 7-segment display driver (4 digits, MM:SS or plain decimal).
- Runs on the single system clock and advances on a one-cycle tick strobe from the clock divider, so no derived clock is used as a flop clock.
- Adds per-digit modulus (decimal 0-9 or sexagesimal-tens 0-5), count direction, wrap or saturate, pause, synchronous clear, parallel load, and carry/borrow reporting.

Parameters:
- NUM_DIGITS, 4: number of BCD digits; legal range 1-8.
- SEXA_MASK, 4'b0010 (width NUM_DIGITS): bit i=1 means digit i counts 0-5; bit i=0 means digit i counts 0-9. The default gives MM:SS.
- WRAP, 1: 1 = roll over at the limits; 0 = saturate at the limits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick_en  in  1  one-cycle count strobe from the divider.
- up_down  in  1  direction: 1 = count up, 0 = count down.
- pause  in  1  when 1, tick_en is ignored.
- clear  in  1  synchronous clear to all zeros.
- load  in  1  synchronous parallel load.
- load_value  in  4*NUM_DIGITS  BCD value to load; digit 0 is in bits [3:0].
- count  out  4*NUM_DIGITS  current BCD value; digit 0 (least significant) is in bits [3:0].
- wrap_pulse  out  1  one-cycle pulse on rollover (up) or underflow (down).
- at_max  out  1  all digits at their limit (9 or 5).
- at_zero  out  1  all digits are 0.

Behaviour:
- Reset (asynchronous, active-high):
  - count = 0, wrap_pulse = 0.
  - at_zero = 1, at_max = 0 (at_max is 1 only when NUM_DIGITS=0, which is illegal).
- Priority on each rising clk edge: clear > load > (tick_en & ~pause). At most one action per cycle.
- Clear: count <= 0 next edge; wrap_pulse = 0.
- Load:
  - Each digit is clamped to its digit max, e.g. a 4'hC on a 0-9 digit loads 9, and a 7 on a 0-5 digit loads 5.
  - wrap_pulse = 0.
  - A load takes effect even when pause=1.
- Count up:
  - Digit 0 increments.
  - A digit at its max goes to 0 and generates a carry into the next digit. This is a ripple within the same cycle: combinational carry chain, single register update.
  - Digits never take values above their max. The values 10-15 are unreachable, except through an out-of-range load, which clamping prevents.
- Count down:
  - Digit 0 decrements.
  - A digit at 0 goes to its max and generates a borrow into the next digit.
- Boundaries:
  - Up from all-max with WRAP=1: count becomes 0 and wrap_pulse = 1 for exactly one cycle, aligned with the new count value.
  - Up from all-max with WRAP=0: count holds, wrap_pulse = 0.
  - Down from 0 with WRAP=1: count becomes all-max and wrap_pulse = 1.
  - Down from 0 with WRAP=0: count holds, wrap_pulse = 0.
- Latency: count changes on the edge where tick_en=1 is sampled. There is 1 cycle from the strobe to the visible output.
- Flags: at_max and at_zero are combinational decodes of the registered count and are valid in the same cycle as count.
- wrap_pulse is registered; it is 0 in every cycle that has no wrap event.
- up_down may change on any cycle. It is sampled only on tick edges, and there is no hysteresis.
- Back-to-back ticks every cycle are legal and count once per cycle.
- Reset asserted mid-operation zeroes the outputs immediately, independent of clk. Operation resumes on the first edge after reset deassertion.

Test Plan:
- Reset then idle: assert rst at arbitrary phase -> count=16'h0000, at_zero=1, wrap_pulse=0 immediately. Ten idle clocks with tick_en=0 -> count unchanged.
- MM:SS carry (defaults): load 16'h0959, up, one tick -> count=16'h1000 one cycle later, wrap_pulse=0. Load 16'h0059 then tick -> 16'h0100.
- Full wrap up (WRAP=1): load 16'h9959, tick -> count=16'h0000, wrap_pulse=1 for exactly one cycle, at_zero=1.
- Down/underflow: count=0, up_down=0, tick -> 16'h9959 with wrap_pulse=1. With WRAP=0, count stays 16'h0000 and wrap_pulse=0.
- Priority and pause:
  - pause=1 with 5 ticks -> count holds.
  - Same cycle clear=1, load=1, tick -> count=0.
  - load with 16'hFC7A -> count=16'h9959 (clamped per digit).
- Decimal config (SEXA_MASK=0, NUM_DIGITS=2): 100 consecutive up ticks from 0 -> count sequences 00..99, then 00 with a single wrap_pulse. Digit values never exceed 9.
